rank_result_capture: RTL

//  Sink at the output end of the rank_order filter stream. Discards the

---
 rtl/rank_result_capture.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rank_result_capture.sv
// ============================================================================
// Module   : rank_result_capture
// Purpose  : Captures DEPTH rank_order filter samples after SKIP fill samples
//            and returns them in order through a registered read port.
//            Optional CAPTURE_MINMAX_EN adds running cap_min/cap_max outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rank_result_capture #(
  parameter int DATA_BITS = 8,
  parameter int SKIP      = 4,
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic [ADDR_BITS:0]   count,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
`ifdef CAPTURE_MINMAX_EN
  ,
  output logic [DATA_BITS-1:0] cap_min,
  output logic [DATA_BITS-1:0] cap_max
`endif
);

  localparam int                 c_skip_bits = (SKIP < 2) ? 1 : $clog2(SKIP + 1);
  localparam logic [c_skip_bits-1:0] c_skip_init = c_skip_bits'(SKIP);
  localparam logic [c_skip_bits-1:0] c_skip_one  = c_skip_bits'(1);
  localparam logic [ADDR_BITS:0] c_cnt_zero = '0;
  localparam logic [ADDR_BITS:0] c_cnt_one  = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS:0] c_cnt_last = (ADDR_BITS + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                 r_state;
  logic [c_skip_bits-1:0] r_skip;
  logic [ADDR_BITS:0]     r_count;
  logic [ADDR_BITS:0]     r_rd_ptr;
  logic [DATA_BITS-1:0]   r_rd_data;
  logic                   r_rd_valid;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_overflow;
  logic [DATA_BITS-1:0]   r_mem [DEPTH];

  logic                   w_start_acc;
  logic                   w_wr;
  logic                   w_rd;
  logic [ADDR_BITS-1:0]   w_wr_addr;
  logic [ADDR_BITS-1:0]   w_rd_addr;

  // start only re-arms from IDLE or DONE; an accepted start also drops any read
  assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_wr        = (r_state == ST_CAPTURE) && in_valid;
  assign w_rd        = rd_en && !w_start_acc && (r_rd_ptr < r_count);
  assign w_wr_addr   = r_count[ADDR_BITS-1:0];
  assign w_rd_addr   = r_rd_ptr[ADDR_BITS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_skip     <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_start_acc) begin
      r_count    <= c_cnt_zero;
      r_overflow <= 1'b0;
      r_skip     <= c_skip_init;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_state    <= (SKIP == 0) ? ST_CAPTURE : ST_FILL;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (in_valid) begin
            r_skip <= r_skip - c_skip_one;
            if (r_skip == c_skip_one) begin
              r_state <= ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (in_valid) begin
            r_count <= r_count + c_cnt_one;
            if (r_count == c_cnt_last) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (in_valid) begin
            r_overflow <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sample storage carries no reset; count gates what is readable
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (w_start_acc) begin
      r_rd_ptr   <= c_cnt_zero;
      r_rd_valid <= 1'b0;
    end else if (w_rd) begin
      r_rd_data  <= r_mem[w_rd_addr];
      r_rd_valid <= 1'b1;
      r_rd_ptr   <= r_rd_ptr + c_cnt_one;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

`ifdef CAPTURE_MINMAX_EN
  logic [DATA_BITS-1:0] r_cap_min;
  logic [DATA_BITS-1:0] r_cap_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_min <= '0;
      r_cap_max <= '0;
    end else if (w_start_acc) begin
      r_cap_min <= '1;
      r_cap_max <= '0;
    end else if (w_wr) begin
      if (in_data < r_cap_min) begin
        r_cap_min <= in_data;
      end
      if (in_data > r_cap_max) begin
        r_cap_max <= in_data;
      end
    end
  end

  assign cap_min = r_cap_min;
  assign cap_max = r_cap_max;
`endif

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign count    = r_count;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;

endmodule

`default_nettype wire
